// File: rtl/sha256_pkg.sv
// SHA-256 shared types, initial hash value and round helper functions.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t       state_t [0:7];

  // Standard initial hash value H0..H7.
  localparam state_t H0 = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Compression Sigma0.
  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  // Compression Sigma1.
  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Schedule sigma0.
  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Schedule sigma1.
  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: 16-word sliding window and W_t generation.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [5:0] i_t,
  input  word_t      i_mt,
  output word_t      o_wt
);

  // r_win[15] holds W[t-1], r_win[0] holds W[t-16].
  word_t r_win [0:15];
  word_t w_wt;

  // W_t: message word for the first 16 rounds, expansion afterwards.
  always_comb begin
    w_wt = i_mt;
    if (i_t >= 6'd16) begin
      w_wt = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];
    end
  end

  // Shift the new W_t into the window on every issued round.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else if (i_en) begin
      for (int unsigned i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_wt;
    end
  end

  assign o_wt = w_wt;

endmodule

// File: rtl/sha256_round_pipe.sv
// SHA-256 round datapath: scheduler, registered Kt+Wt stage and
// 64-round compressor with feed-forward digest.
module sha256_round_pipe
  import sha256_pkg::*;
#(
  parameter logic [3:0] CORE = 4'b0,
  parameter logic [1:0] PASS = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] r_cntr,
  input  word_t      iv_    [0:7],
  input  word_t      kt,
  input  word_t      mt,
  output word_t      wreg   [0:7],
  output word_t      digest [0:7],
  output logic       validOut
);

  // CORE/PASS only tag the instance; this always-true scope keeps them referenced.
  if (CORE <= 4'hF && PASS <= 2'h3) begin : g_instance_tag
  end

  word_t      w_wt;
  word_t      r_ktwt;
  logic [5:0] r_rnd_d;
  logic       r_v_d;
  word_t      r_iv_issue [0:7];
  word_t      r_iv       [0:7];
  word_t      r_wreg     [0:7];
  logic       r_valid;
  word_t      w_s        [0:7];
  word_t      w_t1;
  word_t      w_t2;

  sha256_msg_sched u_sched (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .i_t   (r_cntr),
    .i_mt  (mt),
    .o_wt  (w_wt)
  );

  // Kt+Wt stage: register the round addend and its round index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ktwt  <= '0;
      r_rnd_d <= '0;
      r_v_d   <= 1'b0;
    end else if (en) begin
      r_ktwt  <= kt + w_wt;
      r_rnd_d <= r_cntr;
      r_v_d   <= 1'b1;
    end else begin
      r_v_d   <= 1'b0;
    end
  end

  // IV latch. The issue-time copy seeds round 0; the feed-forward copy
  // only advances once round 0 is applied, so a back-to-back next block
  // cannot disturb the digest of the block reporting validOut.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_iv_issue[i] <= '0;
        r_iv[i]       <= '0;
      end
    end else begin
      if (en && (r_cntr == 6'd0)) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r_iv_issue[i] <= iv_[i];
        end
      end
      if (r_v_d && (r_rnd_d == 6'd0)) begin
        for (int unsigned i = 0; i < 8; i++) begin
          r_iv[i] <= r_iv_issue[i];
        end
      end
    end
  end

  // Round input selection and T1/T2.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      w_s[i] = (r_rnd_d == 6'd0) ? r_iv_issue[i] : r_wreg[i];
    end
    w_t1 = w_s[7] + bsig1(w_s[4]) + ch(w_s[4], w_s[5], w_s[6]) + r_ktwt;
    w_t2 = bsig0(w_s[0]) + maj(w_s[0], w_s[1], w_s[2]);
  end

  // Compressor: apply one round when the Kt+Wt stage is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        r_wreg[i] <= '0;
      end
    end else if (r_v_d) begin
      r_wreg[0] <= w_t1 + w_t2;
      r_wreg[1] <= w_s[0];
      r_wreg[2] <= w_s[1];
      r_wreg[3] <= w_s[2];
      r_wreg[4] <= w_s[3] + w_t1;
      r_wreg[5] <= w_s[4];
      r_wreg[6] <= w_s[5];
      r_wreg[7] <= w_s[6];
    end
  end

  // Completion pulse when round 63 has been applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v_d && (r_rnd_d == 6'd63);
    end
  end

  // Feed-forward addition.
  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      digest[i] = r_wreg[i] + r_iv[i];
    end
  end

  assign wreg     = r_wreg;
  assign validOut = r_valid;

endmodule

// File: tb/tb_sha256_round_pipe.sv
// Directed self-checking bench for sha256_round_pipe.
module tb_sha256_round_pipe;
  import sha256_pkg::*;

  localparam logic [255:0] H0_256   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPT_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPT_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] R0_WREG  = 256'h5d6aebcd6a09e667bb67ae853c6ef372fa2a4622510e527f9b05688c1f83d9ab;

  logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] r_cntr;
  word_t      iv_    [0:7];
  word_t      kt;
  word_t      mt;
  word_t      wreg   [0:7];
  word_t      digest [0:7];
  logic       validOut;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int vcount = 0;
  int vcyc [$];
  logic [255:0] vdig [$];

  sha256_round_pipe #(.CORE(4'd0), .PASS(2'b01)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .r_cntr   (r_cntr),
    .iv_      (iv_),
    .kt       (kt),
    .mt       (mt),
    .wreg     (wreg),
    .digest   (digest),
    .validOut (validOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pack8(input word_t s [0:7]);
    return {s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7]};
  endfunction

  // Record every completion pulse away from the active edge.
  always @(negedge clk) begin
    if (validOut === 1'b1) begin
      vcount = vcount + 1;
      vcyc.push_back(cyc);
      vdig.push_back(pack8(digest));
    end
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  // Straight-line reference compression over a full 64-entry schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = iv[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) | (~v[4] & v[6])) + K[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i] + iv[255-32*i -: 32];
    return res;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue round t; iv_ carries junk except on round 0, mt carries junk from round 16.
  task automatic issue(input int t, input logic [255:0] iv, input logic [511:0] blk);
    logic [31:0] m;
    m = (t < 16) ? blk[511-32*t -: 32] : $urandom;
    en     = 1'b1;
    r_cntr = t[5:0];
    kt     = K[t];
    mt     = m;
    for (int i = 0; i < 8; i++) iv_[i] = (t == 0) ? iv[255-32*i -: 32] : $urandom;
    tick();
  endtask

  task automatic idle();
    en = 1'b0;
    tick();
  endtask

  logic [511:0] rnd_blk;
  logic [511:0] blk2;
  logic [255:0] d0, d1;
  int base, qb, c0, c1;

  initial begin
    rst = 1'b1; en = 1'b0; r_cntr = '0; kt = '0; mt = '0;
    for (int i = 0; i < 8; i++) iv_[i] = '0;
    tick(); tick();
    check("reset_wreg", pack8(wreg), 256'h0);
    check("reset_digest", pack8(digest), 256'h0);
    check("reset_valid", {255'h0, validOut}, 256'h0);
    rst = 1'b0;

    // "abc" with intermediate checks.
    base = vcount;
    issue(0, H0_256, ABC_BLK);
    issue(1, H0_256, ABC_BLK);
    check("abc_round0_wreg", pack8(wreg), R0_WREG);
    for (int t = 2; t <= 16; t++) issue(t, H0_256, ABC_BLK);
    check("abc_w16", {224'h0, dut.u_sched.r_win[15]}, {224'h0, 32'h61626380});
    for (int t = 17; t <= 63; t++) issue(t, H0_256, ABC_BLK);
    check("abc_valid_early", {255'h0, validOut}, 256'h0);
    idle();
    check("abc_valid", {255'h0, validOut}, 256'h1);
    check("abc_digest", pack8(digest), ABC_DIG);
    idle(); idle();
    check("abc_valid_after", {255'h0, validOut}, 256'h0);
    check("abc_pulse_count", 256'(vcount - base), 256'd1);
    check("abc_digest_hold", pack8(digest), ABC_DIG);

    // Empty message with a 3-cycle bubble after round 20.
    for (int t = 0; t <= 20; t++) issue(t, H0_256, EMPT_BLK);
    idle(); idle(); idle();
    for (int t = 21; t <= 63; t++) issue(t, H0_256, EMPT_BLK);
    idle();
    check("empty_valid", {255'h0, validOut}, 256'h1);
    check("empty_digest", pack8(digest), EMPT_DIG);

    // Restart mid-block: abandoned block must not complete.
    for (int i = 0; i < 16; i++) rnd_blk[511-32*i -: 32] = $urandom;
    idle();
    base = vcount;
    for (int t = 0; t <= 30; t++) issue(t, H0_256, rnd_blk);
    for (int t = 0; t <= 63; t++) issue(t, H0_256, ABC_BLK);
    idle();
    check("restart_digest", pack8(digest), ABC_DIG);
    idle();
    check("restart_pulse_count", 256'(vcount - base), 256'd1);

    // Reset at round 40, then a full run.
    for (int t = 0; t <= 39; t++) issue(t, H0_256, ABC_BLK);
    rst = 1'b1;
    issue(40, H0_256, ABC_BLK);
    rst = 1'b0;
    en  = 1'b0;
    check("rst_wreg", pack8(wreg), 256'h0);
    check("rst_digest", pack8(digest), 256'h0);
    check("rst_valid", {255'h0, validOut}, 256'h0);
    base = vcount;
    for (int t = 0; t <= 63; t++) issue(t, H0_256, ABC_BLK);
    idle();
    check("post_rst_digest", pack8(digest), ABC_DIG);
    idle();
    check("post_rst_pulse_count", 256'(vcount - base), 256'd1);

    // Two blocks back-to-back; second IV is the first digest.
    for (int i = 0; i < 16; i++) blk2[511-32*i -: 32] = $urandom;
    base = vcount;
    qb   = vdig.size();
    for (int t = 0; t <= 63; t++) issue(t, H0_256, ABC_BLK);
    for (int t = 0; t <= 63; t++) issue(t, ABC_DIG, blk2);
    idle(); idle(); idle();
    d0 = (vdig.size() > qb)     ? vdig[qb]     : 'x;
    d1 = (vdig.size() > qb + 1) ? vdig[qb + 1] : 'x;
    c0 = (vcyc.size() > qb)     ? vcyc[qb]     : 0;
    c1 = (vcyc.size() > qb + 1) ? vcyc[qb + 1] : 0;
    check("b2b_pulse_count", 256'(vcount - base), 256'd2);
    check("b2b_pulse_gap", 256'(c1 - c0), 256'd64);
    check("b2b_digest0", d0, ref_compress(H0_256, ABC_BLK));
    check("b2b_digest1", d1, ref_compress(ABC_DIG, blk2));
    check("b2b_digest_hold", pack8(digest), ref_compress(ABC_DIG, blk2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
